// File: rtl/vram_arbiter.sv
// Tile/brick-map RAM arbiter: fixed-priority scanout fetches, game-logic access in free slots,
// starvation-forced game grants, and a one-entry skid buffer for the displaced video fetch.
module vram_arbiter #(
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic [DATA_W-1:0] vid_rdata,
    output logic              vid_rvalid,
    input  logic              gl_req,
    input  logic              gl_we,
    input  logic [ADDR_W-1:0] gl_addr,
    input  logic [DATA_W-1:0] gl_wdata,
    output logic              gl_ack,
    output logic [DATA_W-1:0] gl_rdata,
    output logic              gl_rvalid,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    typedef enum logic [2:0] {
        G_IDLE,
        G_FORCE_GL,
        G_BUF_VID,
        G_NEW_VID,
        G_GL
    } grant_t;

    grant_t            grant;
    logic              gl_elig;
    logic              vid_grant;
    logic              gl_grant;

    logic              buf_full, buf_full_nxt;
    logic [ADDR_W-1:0] buf_addr, buf_addr_nxt;
    logic [3:0]        starve_cnt, starve_nxt;

    // Owner tags follow a read through the RAM address and data stages.
    logic              tag0_valid, tag0_vid;
    logic              tag1_valid, tag1_vid;

    always_comb begin
        gl_elig      = gl_req & ~gl_ack;
        grant        = G_IDLE;
        buf_full_nxt = buf_full;
        buf_addr_nxt = buf_addr;
        starve_nxt   = starve_cnt;

        if (gl_elig && starve_cnt == STARVE_LIM)
            grant = G_FORCE_GL;
        else if (buf_full)
            grant = G_BUF_VID;
        else if (vid_req)
            grant = G_NEW_VID;
        else if (gl_elig)
            grant = G_GL;

        vid_grant = (grant == G_BUF_VID) || (grant == G_NEW_VID);
        gl_grant  = (grant == G_FORCE_GL) || (grant == G_GL);

        // Draining and refilling in the same cycle leaves the buffer full with the new fetch.
        if (grant == G_BUF_VID)
            buf_full_nxt = 1'b0;
        if (vid_req && grant != G_NEW_VID) begin
            buf_full_nxt = 1'b1;
            buf_addr_nxt = vid_addr;
        end

        if (!gl_req || gl_grant)
            starve_nxt = '0;
        else if (gl_elig && starve_cnt < STARVE_LIM)
            starve_nxt = starve_cnt + 4'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_full   <= 1'b0;
            buf_addr   <= '0;
            starve_cnt <= '0;
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            gl_ack     <= 1'b0;
            tag0_valid <= 1'b0;
            tag0_vid   <= 1'b0;
            tag1_valid <= 1'b0;
            tag1_vid   <= 1'b0;
            vid_rvalid <= 1'b0;
            vid_rdata  <= '0;
            gl_rvalid  <= 1'b0;
            gl_rdata   <= '0;
        end else begin
            buf_full   <= buf_full_nxt;
            buf_addr   <= buf_addr_nxt;
            starve_cnt <= starve_nxt;

            ram_en <= (grant != G_IDLE);
            ram_we <= 1'b0;
            gl_ack <= gl_grant;
            case (grant)
                G_BUF_VID: ram_addr <= buf_addr;
                G_NEW_VID: ram_addr <= vid_addr;
                G_FORCE_GL, G_GL: begin
                    ram_addr <= gl_addr;
                    ram_we   <= gl_we;
                    if (gl_we)
                        ram_wdata <= gl_wdata;
                end
                default: ;
            endcase

            tag0_valid <= vid_grant | (gl_grant & ~gl_we);
            tag0_vid   <= vid_grant;
            tag1_valid <= tag0_valid;
            tag1_vid   <= tag0_vid;

            vid_rvalid <= tag1_valid & tag1_vid;
            gl_rvalid  <= tag1_valid & ~tag1_vid;
            if (tag1_valid && tag1_vid)
                vid_rdata <= ram_rdata;
            if (tag1_valid && !tag1_vid)
                gl_rdata <= ram_rdata;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: directed scenarios then random traffic, checked each
// cycle against a timed-event scoreboard built from the arbitration rules.
module tb_vram_arbiter;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 8;
    localparam int unsigned SM = 4;
    localparam int unsigned NC = 2400;

    logic          clk;
    logic          reset;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic [DW-1:0] vid_rdata;
    logic          vid_rvalid;
    logic          gl_req;
    logic          gl_we;
    logic [AW-1:0] gl_addr;
    logic [DW-1:0] gl_wdata;
    logic          gl_ack;
    logic [DW-1:0] gl_rdata;
    logic          gl_rvalid;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
        .clk(clk), .reset(reset),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_rdata(vid_rdata), .vid_rvalid(vid_rvalid),
        .gl_req(gl_req), .gl_we(gl_we), .gl_addr(gl_addr), .gl_wdata(gl_wdata),
        .gl_ack(gl_ack), .gl_rdata(gl_rdata), .gl_rvalid(gl_rvalid),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input int unsigned a);
        if (a == 5) return 8'hA5;
        return DW'((a * 37 + 11) ^ (a >> 3));
    endfunction

    // Synchronous RAM: read data appears the cycle after ram_en.
    logic [DW-1:0] mem [1<<AW];
    initial begin
        for (int unsigned i = 0; i < (1 << AW); i++) mem[i] = init_val(i);
        forever begin
            @(posedge clk);
            if (ram_en && !ram_we) ram_rdata <= mem[ram_addr];
            if (ram_en && ram_we)  mem[ram_addr] = ram_wdata;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard of expected events indexed by cycle.
    bit            ev_rst [NC];
    bit            ev_en  [NC];
    bit            ev_we  [NC];
    bit            ev_ack [NC];
    bit            ev_vv  [NC];
    bit            ev_gv  [NC];
    logic [AW-1:0] ev_addr[NC];
    logic [DW-1:0] ev_wd  [NC];
    logic [DW-1:0] ev_vd  [NC];
    logic [DW-1:0] ev_gd  [NC];

    logic [DW-1:0] mmem [1<<AW];
    logic [AW-1:0] vq[$];
    int unsigned   mcnt = 0;
    int unsigned   cyc  = 0;

    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_wd, cur_vd, cur_gd;

    task automatic model(input bit rst, input bit vreq, input logic [AW-1:0] va,
                         input bit greq, input bit gwe, input logic [AW-1:0] ga,
                         input logic [DW-1:0] gd);
        int unsigned   c = cyc;
        bit            elig, ggrant, vissue;
        logic [AW-1:0] vi;
        if (rst) begin
            for (int unsigned k = 1; k <= 3; k++) begin
                ev_en[c+k] = 0; ev_ack[c+k] = 0; ev_vv[c+k] = 0; ev_gv[c+k] = 0;
            end
            ev_rst[c+1] = 1;
            vq.delete();
            mcnt = 0;
            return;
        end
        elig   = greq && !ev_ack[c];
        ggrant = 0;
        vissue = 0;
        vi     = '0;
        if (elig && mcnt == SM) begin
            ggrant = 1;
            if (vreq) vq.push_back(va);
        end else if (vq.size() != 0) begin
            vissue = 1;
            vi = vq.pop_front();
            if (vreq) vq.push_back(va);
        end else if (vreq) begin
            vissue = 1;
            vi = va;
        end else if (elig) begin
            ggrant = 1;
        end
        if (!greq || ggrant) mcnt = 0;
        else if (elig && mcnt < SM) mcnt++;
        if (vissue) begin
            ev_en[c+1] = 1; ev_we[c+1] = 0; ev_addr[c+1] = vi;
            ev_vv[c+3] = 1; ev_vd[c+3] = mmem[vi];
        end
        if (ggrant) begin
            ev_en[c+1] = 1; ev_we[c+1] = gwe; ev_addr[c+1] = ga; ev_ack[c+1] = 1;
            if (gwe) begin
                ev_wd[c+1] = gd;
                mmem[ga] = gd;
            end else begin
                ev_gv[c+3] = 1; ev_gd[c+3] = mmem[ga];
            end
        end
    endtask

    task automatic check_cycle(input int unsigned c);
        if (ev_rst[c]) begin
            cur_addr = '0; cur_wd = '0; cur_vd = '0; cur_gd = '0;
        end
        if (ev_en[c]) begin
            cur_addr = ev_addr[c];
            if (ev_we[c]) cur_wd = ev_wd[c];
        end
        if (ev_vv[c]) cur_vd = ev_vd[c];
        if (ev_gv[c]) cur_gd = ev_gd[c];
        chk("ram_en",     32'(ram_en),     32'(ev_en[c]));
        chk("ram_we",     32'(ram_we),     32'(ev_en[c] && ev_we[c]));
        chk("ram_addr",   32'(ram_addr),   32'(cur_addr));
        chk("ram_wdata",  32'(ram_wdata),  32'(cur_wd));
        chk("gl_ack",     32'(gl_ack),     32'(ev_ack[c]));
        chk("vid_rvalid", 32'(vid_rvalid), 32'(ev_vv[c]));
        chk("vid_rdata",  32'(vid_rdata),  32'(cur_vd));
        chk("gl_rvalid",  32'(gl_rvalid),  32'(ev_gv[c]));
        chk("gl_rdata",   32'(gl_rdata),   32'(cur_gd));
    endtask

    task automatic step(input bit rst, input bit vreq, input logic [AW-1:0] va,
                        input bit greq, input bit gwe, input logic [AW-1:0] ga,
                        input logic [DW-1:0] gd);
        if (cyc + 4 >= NC) begin
            $display("FAIL cycle_budget observed=%0d limit=%0d", cyc, NC - 4);
            $fatal(1, "cycle budget exhausted");
        end
        reset = rst; vid_req = vreq; vid_addr = va;
        gl_req = greq; gl_we = gwe; gl_addr = ga; gl_wdata = gd;
        model(rst, vreq, va, greq, gwe, ga, gd);
        @(posedge clk);
        #1;
        cyc++;
        check_cycle(cyc);
    endtask

    task automatic idle();
        step(0, 0, '0, 0, 0, '0, '0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int            ack_i;
        bit            g_req, g_we, g_done;
        logic [AW-1:0] g_addr;
        logic [DW-1:0] g_wd;

        for (int unsigned i = 0; i < (1 << AW); i++) mmem[i] = init_val(i);

        repeat (3) step(1, 0, '0, 0, 0, '0, '0);
        repeat (2) idle();

        // Isolated video fetch of the 0xA5 word
        step(0, 1, 10'd5, 0, 0, '0, '0);
        chk("iso_ram_en", 32'(ram_en), 32'd1);
        chk("iso_ram_addr", 32'(ram_addr), 32'd5);
        idle();
        idle();
        chk("iso_vid_rvalid", 32'(vid_rvalid), 32'd1);
        chk("iso_vid_rdata", 32'(vid_rdata), 32'hA5);
        idle();

        // Game write then read-back
        step(0, 0, '0, 1, 1, 10'd7, 8'h3C);
        chk("wr_ack", 32'(gl_ack), 32'd1);
        chk("wr_ram_we", 32'(ram_we), 32'd1);
        idle();
        step(0, 0, '0, 1, 0, 10'd7, '0);
        chk("rd_ack", 32'(gl_ack), 32'd1);
        idle();
        idle();
        chk("rd_rvalid", 32'(gl_rvalid), 32'd1);
        chk("rd_rdata", 32'(gl_rdata), 32'h3C);
        idle();

        // Simultaneous video and game requests
        step(0, 1, 10'd1, 1, 0, 10'd2, '0);
        chk("sim_vid_addr", 32'(ram_addr), 32'd1);
        chk("sim_no_ack_yet", 32'(gl_ack), 32'd0);
        step(0, 0, '0, 1, 0, 10'd2, '0);
        chk("sim_gl_ack", 32'(gl_ack), 32'd1);
        chk("sim_gl_addr", 32'(ram_addr), 32'd2);
        repeat (4) idle();

        // Starvation under continuous video traffic
        ack_i = -1;
        for (int i = 0; i < 12; i++) begin
            step(0, 1, AW'(i), ack_i < 0, 0, 10'd9, '0);
            if (gl_ack === 1'b1 && ack_i < 0) ack_i = i;
        end
        chk("starve_ack_step", 32'(ack_i), 32'(SM));
        repeat (5) idle();

        // Ack masking: request held through the ack cycle, new address after
        step(0, 0, '0, 1, 0, 10'd20, '0);
        chk("mask_ack1", 32'(gl_ack), 32'd1);
        step(0, 0, '0, 1, 0, 10'd20, '0);
        chk("mask_no_dup_ack", 32'(gl_ack), 32'd0);
        chk("mask_no_dup_en", 32'(ram_en), 32'd0);
        step(0, 0, '0, 1, 0, 10'd21, '0);
        chk("mask_ack2", 32'(gl_ack), 32'd1);
        chk("mask_addr2", 32'(ram_addr), 32'd21);
        repeat (4) idle();

        // Reset while a fetch is in flight
        step(0, 1, 10'd3, 0, 0, '0, '0);
        step(1, 0, '0, 0, 0, '0, '0);
        chk("rst_ram_en", 32'(ram_en), 32'd0);
        chk("rst_ram_addr", 32'(ram_addr), 32'd0);
        chk("rst_ram_wdata", 32'(ram_wdata), 32'd0);
        chk("rst_vid_rdata", 32'(vid_rdata), 32'd0);
        idle();
        chk("rst_no_rvalid", 32'(vid_rvalid), 32'd0);
        idle();
        step(0, 1, 10'd3, 0, 0, '0, '0);
        idle();
        idle();
        chk("post_rst_rvalid", 32'(vid_rvalid), 32'd1);
        chk("post_rst_rdata", 32'(vid_rdata), 32'(mmem[3]));
        idle();

        // Random traffic
        g_req = 0; g_we = 0; g_done = 0; g_addr = '0; g_wd = '0;
        for (int n = 0; n < 1500; n++) begin
            if (g_done) begin
                g_done = 0;
                g_req  = ($urandom_range(9) < 7);
                g_we   = $urandom_range(1) == 1;
                g_addr = AW'($urandom_range(63));
                g_wd   = DW'($urandom);
            end else if (!g_req && $urandom_range(9) < 4) begin
                g_req  = 1;
                g_we   = $urandom_range(1) == 1;
                g_addr = AW'($urandom_range(63));
                g_wd   = DW'($urandom);
            end
            if (ev_ack[cyc]) g_done = 1;
            step($urandom_range(99) == 0, $urandom_range(1) == 1, AW'($urandom_range(63)),
                 g_req, g_we, g_addr, g_wd);
        end
        repeat (6) idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Arbiter for the single-port tile/brick-map RAM shared by the VGA scanout path and the Breakout game logic. Scanout tile fetches have fixed priority. Game-logic reads and writes use free slots, with a starvation counter that forces a game grant. A one-entry skid buffer holds the displaced video fetch, so no scanout fetch is lost. Sits between the pixel-timing/scanout block, the game state machine and the RAM, all in the 25 MHz pixel clock domain.

## Interface
- ADDR_W, 10, RAM address width (80x60 tile map fits 4800 < 2^13; set per build)
- DATA_W, 8, RAM word width
- STARVE_MAX, 4, wait cycles before a forced game-logic grant; legal range 1..15
- clk  in  1  pixel clock; one clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- vid_req  in  1  single-cycle fetch pulse from scanout; no backpressure
- vid_addr  in  ADDR_W  fetch address, valid with vid_req
- vid_rdata  out  DATA_W  fetched word
- vid_rvalid  out  1  one-cycle pulse, vid_rdata valid
- gl_req  in  1  game-logic request; held with addr/we/wdata stable until gl_ack
- gl_we  in  1  1 = write, 0 = read
- gl_addr  in  ADDR_W  access address
- gl_wdata  in  DATA_W  write data
- gl_ack  out  1  one-cycle pulse, request accepted
- gl_rdata  out  DATA_W  read data
- gl_rvalid  out  1  one-cycle pulse, gl_rdata valid (reads only)
- ram_en, ram_we  out  1  registered RAM strobes
- ram_addr  out  ADDR_W  registered RAM address
- ram_wdata  out  DATA_W  registered RAM write data
- ram_rdata  in  DATA_W  RAM read data, valid 1 cycle after ram_en & !ram_we

## Operation
- gl eligible in cycle N: gl_req=1 and N is not a mask cycle. A mask cycle is the cycle in which gl_ack is high.
- Arbitration is evaluated each cycle N on sampled inputs. First match wins:
  1. FORCE_GL: gl eligible and starve_cnt==STARVE_MAX.
  2. BUF_VID: skid buffer full.
  3. NEW_VID: vid_req.
  4. GL: gl eligible.
  5. IDLE.
- Skid buffer:
  - When vid_req is not served in N, {vid_addr} is captured and the buffer is marked full.
  - BUF_VID frees the buffer. If vid_req arrives in the same cycle, the new request is captured, so the buffer stays full.
  - The buffer can never need two entries. The buffer fills only on FORCE_GL; the counter is 0 the next cycle, so BUF_VID always drains it.
- starve_cnt (4 bits):
  - Cleared on reset, on any gl grant, and on any cycle gl_req=0.
  - Incremented on each cycle gl is eligible but not granted.
  - Never exceeds STARVE_MAX.
- Owner tag: a 2-stage pipeline of {valid, is_vid}, set on read grants only. It routes ram_rdata to the vid or gl return port. Writes produce no return.
- Ordering: video fetches return in issue order. Buffered fetches are never overtaken by later video fetches.

## Timing
- Grant in cycle N:
  - ram_en/ram_we/ram_addr/ram_wdata driven in N+1 for one cycle.
  - ram_rdata is sampled in N+2.
  - vid_rdata/vid_rvalid or gl_rdata/gl_rvalid are registered and asserted in N+3.
- Latency:
  - Unbuffered video: 3 cycles from vid_req.
  - Buffered video: 4 cycles.
- gl_ack asserted in N+1 for a gl grant in N. It coincides with ram_en. N+1 is a mask cycle; gl_req is ignored then.
- Idle cycles: ram_en=0 and ram_we=0. ram_addr and ram_wdata hold their last value.
- Reset values: every output is 0. Skid buffer empty, starve_cnt=0, owner pipeline invalid.
- Reset mid-operation: in-flight reads are discarded. No rvalid pulses follow reset. A pending gl request is re-arbitrated from scratch after reset.
- Max one grant per cycle. Throughput is 1 access/cycle.

## Test plan
- Isolated video fetch:
  - Stimulus: RAM[5]=0xA5; vid_req with addr 5 at cycle 10.
  - Response: ram_en=1, ram_addr=5 at 11; vid_rvalid=1, vid_rdata=0xA5 at 13; gl_* outputs stay 0.
- Game write then read:
  - Stimulus: gl write of 0x3C to addr 7, then gl read of addr 7.
  - Response: write → gl_ack one cycle after request, ram_we=1, no gl_rvalid. Read → gl_ack, then gl_rvalid with 0x3C two cycles later.
- Simultaneous requests:
  - Stimulus: vid_req (addr 1) and gl_req (addr 2) at cycle 20.
  - Response: ram_addr=1 at 21; gl granted at 21 with gl_ack at 22, ram_addr=2 at 22.
- Starvation, STARVE_MAX=4:
  - Stimulus: vid_req every cycle from 30 with addrs 0,1,2,…; gl_req held from 30.
  - Response: forced gl grant at 34, gl_ack at 35. Video addr 4 buffered and issued at 35. Every video address returns exactly once, in order. A vid_rvalid gap appears where the gl access sits.
- Ack masking:
  - Stimulus: gl_req held high across gl_ack with a new addr presented the cycle after ack.
  - Response: no duplicate access in the ack cycle; second grant no earlier than the cycle after ack.
- Reset mid-flight:
  - Stimulus: vid_req at 40, reset high at 41 for one cycle.
  - Response: no vid_rvalid at 43; all outputs 0 at 42; a fresh vid_req at 45 returns correct data at 48.
